core_hazard_ctrl: RTL and testbench
===================================

Name: core_hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB).
- Tracks in-flight register writers in a scoreboard.
- Detects RAW hazards and data-memory wait, and handles EX-stage redirects (taken branch/jump).
- Drives the per-stage stall, flush and bubble controls for the inter-stage registers, plus the operand forwarding selects for EX.

Parameters:
- RFIDX_W, 5, register index width.
- NUM_REGS, 32, architectural registers; x0 never tracked.
- FLUSH_CYCLES, 1, cycles of IF/ID kill after a redirect; legal range 1..3.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- id_valid  in  1  valid instruction in ID
- id_rs1_ren, id_rs2_ren  in  1  source reads used
- id_rs1_idx, id_rs2_idx, id_rsd_idx  in  RFIDX_W  source/destination indices
- id_rsd_wen  in  1  ID instruction writes rd
- ex_valid, ex_rsd_wen, ex_is_load  in  1  EX-stage producer info
- ex_rsd_idx  in  RFIDX_W  EX destination
- mem_valid, mem_rsd_wen  in  1  MEM-stage producer info
- mem_rsd_idx  in  RFIDX_W  MEM destination
- wb_valid, wb_rsd_wen  in  1  WB retire write
- wb_rsd_idx  in  RFIDX_W  WB destination
- ex_redirect  in  1  taken branch/jump resolved in EX
- mem_busy  in  1  data memory not ready
- if_stall  out  1  hold PC
- id_stall  out  1  hold if2id register
- if2id_flush  out  1  kill if2id contents
- id2ex_bubble  out  1  load NOP into id2ex
- ex_stall, mem_stall  out  1  hold id2ex/ex2mem registers
- mem2wb_bubble  out  1  load NOP into mem2wb
- fwd_rs1_sel, fwd_rs2_sel  out  2  00 regfile, 01 ex2mem, 10 mem2wb

Behaviour:
- FSM states and transitions:
  - INIT: entered on reset. Asserts if2id_flush and id2ex_bubble, then goes to RUN.
  - RUN -> MWAIT: mem_busy.
  - RUN -> FLUSH: ex_redirect, with counter loaded to FLUSH_CYCLES-1.
  - RUN -> HAZ: hazard.
  - HAZ -> RUN: hazard clear.
  - FLUSH -> RUN: counter reaches 0.
  - MWAIT -> RUN: ~mem_busy.
- Priority in any state: mem_busy > ex_redirect > hazard.
- Outputs are combinational from state and inputs. Reset values while rst_n=0: if2id_flush=1, id2ex_bubble=1, all other outputs 0, fwd sels 00.
- mem_busy:
  - Asserts if_stall, id_stall, ex_stall, mem_stall and mem2wb_bubble in the same cycle.
  - ex_redirect is ignored while mem_busy; EX holds it asserted.
- ex_redirect:
  - Asserts if2id_flush and id2ex_bubble in the same cycle and for FLUSH_CYCLES total cycles.
  - No stalls are asserted; any pending hazard is discarded.
- Hazard:
  - Asserts if_stall, id_stall and id2ex_bubble.
  - EX and later stages continue.
- Scoreboard (busy[NUM_REGS-1:1]):
  - Set: on issue, i.e. id_valid & ~id_stall & ~id2ex_bubble & id_rsd_wen & rsd!=0.
  - Clear: on wb_valid & wb_rsd_wen.
  - Same-index set and clear in one cycle: set wins.
  - Flushed and bubbled instructions never set bits.
  - Reset clears all bits.
- Hazard condition without forwarding: id_valid and an enabled source has busy[idx]=1.
  - Regfile is not write-through, so a register cleared by WB in this cycle still stalls this cycle.
  - A source index of 0 never stalls.
- Hazard condition with forwarding: see Optional Feature.
- All index compares are RFIDX_W-bit equality.

Optional Feature:
Macro: CORE_FWD_EN.
- Defined:
  - Hazard condition is the load-use case only: ex_valid & ex_is_load & ex_rsd_wen & ex_rsd_idx!=0 & matches an enabled ID source. This stalls exactly 1 cycle.
  - Forward selects are computed for each source: 01 if EX producer matches (non-load), else 10 if MEM producer matches, else 00. The youngest producer wins. Index 0 gives 00.
  - The scoreboard is still maintained.
- Undefined: fwd_*_sel are tied to 00 and the scoreboard hazard rule applies.

Test Plan:
- Reset held 3 cycles, then released -> if2id_flush=1 and id2ex_bubble=1 during reset and for 1 cycle after; then all outputs 0.
- Issue rd=x5, next ID reads rs1=x5 (no FWD) -> if_stall/id_stall/id2ex_bubble held until the cycle after WB writes x5 (3 stall cycles); x0 source never stalls.
- CORE_FWD_EN: load rd=x7 in EX, ID reads rs2=x7 -> exactly 1 stall cycle, then fwd_rs2_sel=10. ALU rd=x7 in EX -> no stall, fwd_rs2_sel=01.
- ex_redirect pulse while a hazard is pending, FLUSH_CYCLES=2 -> if2id_flush/id2ex_bubble for 2 cycles, no stall; the flushed rd never set in scoreboard.
- mem_busy high 4 cycles with ex_redirect=1 -> all stage stalls plus mem2wb_bubble for 4 cycles; flush begins the cycle mem_busy drops.
- WB clears x9 and ID issues new writer to x9 in the same cycle -> busy[9] remains 1.

Source files
------------

// File: rtl/core_hazard_ctrl_if.sv
// Hazard-controller bundle: producer/consumer info from the pipeline stages,
// stage stall/flush/bubble controls and EX forwarding selects back.
interface core_hazard_ctrl_if #(
    parameter int RFIDX_W = 5
);
    logic               id_valid;
    logic               id_rs1_ren;
    logic               id_rs2_ren;
    logic [RFIDX_W-1:0] id_rs1_idx;
    logic [RFIDX_W-1:0] id_rs2_idx;
    logic [RFIDX_W-1:0] id_rsd_idx;
    logic               id_rsd_wen;
    logic               ex_valid;
    logic               ex_rsd_wen;
    logic               ex_is_load;
    logic [RFIDX_W-1:0] ex_rsd_idx;
    logic               mem_valid;
    logic               mem_rsd_wen;
    logic [RFIDX_W-1:0] mem_rsd_idx;
    logic               wb_valid;
    logic               wb_rsd_wen;
    logic [RFIDX_W-1:0] wb_rsd_idx;
    logic               ex_redirect;
    logic               mem_busy;
    logic               if_stall;
    logic               id_stall;
    logic               if2id_flush;
    logic               id2ex_bubble;
    logic               ex_stall;
    logic               mem_stall;
    logic               mem2wb_bubble;
    logic [1:0]         fwd_rs1_sel;
    logic [1:0]         fwd_rs2_sel;

    modport master (
        output id_valid, id_rs1_ren, id_rs2_ren, id_rs1_idx, id_rs2_idx, id_rsd_idx, id_rsd_wen,
        output ex_valid, ex_rsd_wen, ex_is_load, ex_rsd_idx,
        output mem_valid, mem_rsd_wen, mem_rsd_idx,
        output wb_valid, wb_rsd_wen, wb_rsd_idx,
        output ex_redirect, mem_busy,
        input  if_stall, id_stall, if2id_flush, id2ex_bubble, ex_stall, mem_stall, mem2wb_bubble,
        input  fwd_rs1_sel, fwd_rs2_sel
    );

    modport slave (
        input  id_valid, id_rs1_ren, id_rs2_ren, id_rs1_idx, id_rs2_idx, id_rsd_idx, id_rsd_wen,
        input  ex_valid, ex_rsd_wen, ex_is_load, ex_rsd_idx,
        input  mem_valid, mem_rsd_wen, mem_rsd_idx,
        input  wb_valid, wb_rsd_wen, wb_rsd_idx,
        input  ex_redirect, mem_busy,
        output if_stall, id_stall, if2id_flush, id2ex_bubble, ex_stall, mem_stall, mem2wb_bubble,
        output fwd_rs1_sel, fwd_rs2_sel
    );
endinterface

// File: rtl/core_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: scoreboard, RAW/load-use hazards, memory wait,
// EX redirect flush. Define CORE_FWD_EN to enable EX operand forwarding (load-use stalls only).
module core_hazard_ctrl #(
    parameter int RFIDX_W      = 5,
    parameter int NUM_REGS     = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    core_hazard_ctrl_if.slave hz
);
    typedef enum logic [2:0] {S_INIT, S_RUN, S_HAZ, S_FLUSH, S_MWAIT} state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                hazard;
    logic                issue;
    logic                if_stall, id_stall, if2id_flush, id2ex_bubble;
    logic                ex_stall, mem_stall, mem2wb_bubble;
    logic [1:0]          fwd_rs1_sel, fwd_rs2_sel;

    function automatic logic tracked(input logic [RFIDX_W-1:0] idx);
        return (idx != '0) && (int'(idx) < NUM_REGS);
    endfunction

`ifdef CORE_FWD_EN
    logic ex_wr, mem_wr;

    assign ex_wr  = hz.ex_valid & hz.ex_rsd_wen & (hz.ex_rsd_idx != '0);
    assign mem_wr = hz.mem_valid & hz.mem_rsd_wen & (hz.mem_rsd_idx != '0);

    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign hazard = hz.id_valid & ex_wr & hz.ex_is_load &
                    ((hz.id_rs1_ren & (hz.id_rs1_idx == hz.ex_rsd_idx)) |
                     (hz.id_rs2_ren & (hz.id_rs2_idx == hz.ex_rsd_idx)));

    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (hz.id_rs1_idx != '0) begin
            if (ex_wr & ~hz.ex_is_load & (hz.ex_rsd_idx == hz.id_rs1_idx))
                fwd_rs1_sel = 2'b01;
            else if (mem_wr & (hz.mem_rsd_idx == hz.id_rs1_idx))
                fwd_rs1_sel = 2'b10;
        end
        if (hz.id_rs2_idx != '0) begin
            if (ex_wr & ~hz.ex_is_load & (hz.ex_rsd_idx == hz.id_rs2_idx))
                fwd_rs2_sel = 2'b01;
            else if (mem_wr & (hz.mem_rsd_idx == hz.id_rs2_idx))
                fwd_rs2_sel = 2'b10;
        end
        if (!rst_n) begin
            fwd_rs1_sel = 2'b00;
            fwd_rs2_sel = 2'b00;
        end
    end
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{hz.ex_valid, hz.ex_rsd_wen, hz.ex_is_load, hz.ex_rsd_idx,
                                 hz.mem_valid, hz.mem_rsd_wen, hz.mem_rsd_idx};

    // The regfile is not write-through, so a register retiring this cycle still stalls.
    assign hazard = hz.id_valid &
                    ((hz.id_rs1_ren & tracked(hz.id_rs1_idx) & busy_q[hz.id_rs1_idx]) |
                     (hz.id_rs2_ren & tracked(hz.id_rs2_idx) & busy_q[hz.id_rs2_idx]));
    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;
`endif

    // Priority mem_busy > ex_redirect > hazard; a memory wait freezes a flush in progress.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        if_stall      = 1'b0;
        id_stall      = 1'b0;
        if2id_flush   = 1'b0;
        id2ex_bubble  = 1'b0;
        ex_stall      = 1'b0;
        mem_stall     = 1'b0;
        mem2wb_bubble = 1'b0;
        if (state_q == S_INIT) begin
            if2id_flush  = 1'b1;
            id2ex_bubble = 1'b1;
            state_d      = S_RUN;
        end else if (hz.mem_busy) begin
            if_stall      = 1'b1;
            id_stall      = 1'b1;
            ex_stall      = 1'b1;
            mem_stall     = 1'b1;
            mem2wb_bubble = 1'b1;
            if (state_q != S_FLUSH)
                state_d = S_MWAIT;
        end else if (hz.ex_redirect) begin
            if2id_flush  = 1'b1;
            id2ex_bubble = 1'b1;
            cnt_d        = FLUSH_LOAD;
            state_d      = (FLUSH_LOAD == 2'd0) ? S_RUN : S_FLUSH;
        end else if (state_q == S_FLUSH) begin
            if2id_flush  = 1'b1;
            id2ex_bubble = 1'b1;
            cnt_d        = cnt_q - 2'd1;
            if (cnt_q <= 2'd1)
                state_d = S_RUN;
        end else if (hazard) begin
            if_stall     = 1'b1;
            id_stall     = 1'b1;
            id2ex_bubble = 1'b1;
            state_d      = S_HAZ;
        end else begin
            state_d = S_RUN;
        end
    end

    assign issue = hz.id_valid & ~id_stall & ~id2ex_bubble & hz.id_rsd_wen & tracked(hz.id_rsd_idx);

    // Set is applied after clear so a same-cycle retire and re-issue keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (hz.wb_valid & hz.wb_rsd_wen & tracked(hz.wb_rsd_idx))
            busy_d[hz.wb_rsd_idx] = 1'b0;
        if (issue)
            busy_d[hz.id_rsd_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= 2'd0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign hz.if_stall      = rst_n & if_stall;
    assign hz.id_stall      = rst_n & id_stall;
    assign hz.if2id_flush   = ~rst_n | if2id_flush;
    assign hz.id2ex_bubble  = ~rst_n | id2ex_bubble;
    assign hz.ex_stall      = rst_n & ex_stall;
    assign hz.mem_stall     = rst_n & mem_stall;
    assign hz.mem2wb_bubble = rst_n & mem2wb_bubble;
    assign hz.fwd_rs1_sel   = fwd_rs1_sel;
    assign hz.fwd_rs2_sel   = fwd_rs2_sel;
endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Testbench for core_hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a rule-level model of the controller.
module tb_core_hazard_ctrl;
    localparam int FC = 2;

    // Output vector bit order: if_stall, id_stall, if2id_flush, id2ex_bubble, ex_stall,
    // mem_stall, mem2wb_bubble, fwd_rs1_sel[1:0], fwd_rs2_sel[1:0].
    localparam logic [10:0] O_NONE  = 11'b00000000000;
    localparam logic [10:0] O_HAZ   = 11'b11010000000;
    localparam logic [10:0] O_FLUSH = 11'b00110000000;
    localparam logic [10:0] O_MWAIT = 11'b11001110000;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    bit [31:0] m_sb   = '0;
    bit        m_init = 1'b0;
    int        m_fl   = 0;

    core_hazard_ctrl_if #(.RFIDX_W(5)) hif ();

    core_hazard_ctrl #(
        .RFIDX_W     (5),
        .NUM_REGS    (32),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] act_vec();
        return {hif.if_stall, hif.id_stall, hif.if2id_flush, hif.id2ex_bubble, hif.ex_stall,
                hif.mem_stall, hif.mem2wb_bubble, hif.fwd_rs1_sel, hif.fwd_rs2_sel};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

`ifdef CORE_FWD_EN
    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (hif.ex_valid && hif.ex_rsd_wen && !hif.ex_is_load && hif.ex_rsd_idx == rs) return 2'b01;
        if (hif.mem_valid && hif.mem_rsd_wen && hif.mem_rsd_idx == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit model_hazard();
        return hif.id_valid && hif.ex_valid && hif.ex_is_load && hif.ex_rsd_wen &&
               hif.ex_rsd_idx != 5'd0 &&
               ((hif.id_rs1_ren && hif.id_rs1_idx == hif.ex_rsd_idx) ||
                (hif.id_rs2_ren && hif.id_rs2_idx == hif.ex_rsd_idx));
    endfunction
`else
    function automatic bit model_hazard();
        return hif.id_valid &&
               ((hif.id_rs1_ren && hif.id_rs1_idx != 5'd0 && m_sb[hif.id_rs1_idx]) ||
                (hif.id_rs2_ren && hif.id_rs2_idx != 5'd0 && m_sb[hif.id_rs2_idx]));
    endfunction
`endif

    // Rule-level model: what the stage controls must be this cycle, then advance its state.
    task automatic model_step();
        logic [10:0] e;
        bit          iss;
        e = O_NONE;
        if (!rst_n) begin
            e      = O_FLUSH;
            m_init = 1'b1;
            m_sb   = '0;
            m_fl   = 0;
        end else begin
            if (m_init) begin
                e      = O_FLUSH;
                m_init = 1'b0;
            end else if (hif.mem_busy) begin
                e = O_MWAIT;
            end else if (hif.ex_redirect) begin
                e    = O_FLUSH;
                m_fl = FC - 1;
            end else if (m_fl > 0) begin
                e = O_FLUSH;
                m_fl--;
            end else if (model_hazard()) begin
                e = O_HAZ;
            end
`ifdef CORE_FWD_EN
            e[3:2] = fwd_of(hif.id_rs1_idx);
            e[1:0] = fwd_of(hif.id_rs2_idx);
`endif
            iss = hif.id_valid && !e[9] && !e[7] && hif.id_rsd_wen && hif.id_rsd_idx != 5'd0;
            if (hif.wb_valid && hif.wb_rsd_wen) m_sb[hif.wb_rsd_idx] = 1'b0;
            if (iss) m_sb[hif.id_rsd_idx] = 1'b1;
            m_sb[0] = 1'b0;
        end
        check("model", act_vec(), e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic idle();
        hif.id_valid    = 1'b0;
        hif.id_rs1_ren  = 1'b0;
        hif.id_rs2_ren  = 1'b0;
        hif.id_rs1_idx  = 5'd0;
        hif.id_rs2_idx  = 5'd0;
        hif.id_rsd_idx  = 5'd0;
        hif.id_rsd_wen  = 1'b0;
        hif.ex_valid    = 1'b0;
        hif.ex_rsd_wen  = 1'b0;
        hif.ex_is_load  = 1'b0;
        hif.ex_rsd_idx  = 5'd0;
        hif.mem_valid   = 1'b0;
        hif.mem_rsd_wen = 1'b0;
        hif.mem_rsd_idx = 5'd0;
        hif.wb_valid    = 1'b0;
        hif.wb_rsd_wen  = 1'b0;
        hif.wb_rsd_idx  = 5'd0;
        hif.ex_redirect = 1'b0;
        hif.mem_busy    = 1'b0;
    endtask

    task automatic set_id(input bit v, input bit r1en, input int r1, input bit r2en, input int r2,
                          input bit wen, input int rd);
        hif.id_valid   = v;
        hif.id_rs1_ren = r1en;
        hif.id_rs1_idx = 5'(r1);
        hif.id_rs2_ren = r2en;
        hif.id_rs2_idx = 5'(r2);
        hif.id_rsd_wen = wen;
        hif.id_rsd_idx = 5'(rd);
    endtask

    task automatic set_wb(input int rd);
        hif.wb_valid   = 1'b1;
        hif.wb_rsd_wen = 1'b1;
        hif.wb_rsd_idx = 5'(rd);
    endtask

    // Check the settled outputs at the falling edge, then move just past the next rising edge.
    task automatic cyc(input string name, input logic [10:0] exp);
        @(negedge clk);
        check(name, act_vec(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_hold", act_vec(), O_FLUSH);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("init_cycle", O_FLUSH);
        cyc("run_idle", O_NONE);

`ifndef CORE_FWD_EN
        idle(); set_id(1, 0, 0, 0, 0, 1, 5);
        cyc("raw_issue", O_NONE);
        idle(); set_id(1, 1, 5, 0, 0, 0, 0);
        hif.ex_valid = 1'b1; hif.ex_rsd_wen = 1'b1; hif.ex_rsd_idx = 5'd5;
        cyc("raw_stall1", O_HAZ);
        idle(); set_id(1, 1, 5, 0, 0, 0, 0);
        hif.mem_valid = 1'b1; hif.mem_rsd_wen = 1'b1; hif.mem_rsd_idx = 5'd5;
        cyc("raw_stall2", O_HAZ);
        idle(); set_id(1, 1, 5, 0, 0, 0, 0); set_wb(5);
        cyc("raw_stall3_wb", O_HAZ);
        idle(); set_id(1, 1, 5, 0, 0, 0, 0);
        cyc("raw_release", O_NONE);
        idle(); set_id(1, 0, 0, 0, 0, 1, 0);
        cyc("x0_write", O_NONE);
        idle(); set_id(1, 1, 0, 1, 0, 0, 0);
        cyc("x0_read", O_NONE);
`else
        idle(); set_id(1, 0, 0, 1, 7, 0, 0);
        hif.ex_valid = 1'b1; hif.ex_is_load = 1'b1; hif.ex_rsd_wen = 1'b1; hif.ex_rsd_idx = 5'd7;
        cyc("load_use_stall", O_HAZ);
        idle(); set_id(1, 0, 0, 1, 7, 0, 0);
        hif.mem_valid = 1'b1; hif.mem_rsd_wen = 1'b1; hif.mem_rsd_idx = 5'd7;
        cyc("load_use_fwd_mem", 11'b00000000010);
        idle(); set_id(1, 0, 0, 1, 7, 0, 0);
        hif.ex_valid = 1'b1; hif.ex_rsd_wen = 1'b1; hif.ex_rsd_idx = 5'd7;
        cyc("alu_fwd_ex", 11'b00000000001);
`endif

        idle(); set_id(1, 0, 0, 0, 0, 1, 3);
        cyc("redir_setup", O_NONE);
        idle(); set_id(1, 1, 3, 0, 0, 1, 11); hif.ex_redirect = 1'b1;
        cyc("redir_flush1", O_FLUSH);
        idle(); set_id(1, 1, 3, 0, 0, 1, 11);
        cyc("redir_flush2", O_FLUSH);
        idle(); set_id(1, 1, 11, 0, 0, 0, 0); set_wb(3);
        cyc("redir_x11_free", O_NONE);

        for (int i = 0; i < 4; i++) begin
            idle(); set_id(1, 0, 0, 0, 0, 0, 0);
            hif.mem_busy = 1'b1; hif.ex_redirect = 1'b1;
            cyc("mwait", O_MWAIT);
        end
        idle(); hif.ex_redirect = 1'b1;
        cyc("mwait_redirect", O_FLUSH);
        idle();
        cyc("mwait_flush2", O_FLUSH);
        idle();
        cyc("mwait_done", O_NONE);

`ifndef CORE_FWD_EN
        idle(); set_id(1, 0, 0, 0, 0, 1, 9);
        cyc("x9_issue", O_NONE);
        idle(); set_id(1, 0, 0, 0, 0, 1, 9); set_wb(9);
        cyc("x9_set_and_clear", O_NONE);
        idle(); set_id(1, 1, 9, 0, 0, 0, 0);
        cyc("x9_still_busy", O_HAZ);
        idle(); set_id(1, 1, 9, 0, 0, 0, 0); set_wb(9);
        cyc("x9_wb_stall", O_HAZ);
        idle(); set_id(1, 1, 9, 0, 0, 0, 0);
        cyc("x9_free", O_NONE);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 299) != 0);
            hif.id_valid    = ($urandom_range(0, 3) != 0);
            hif.id_rs1_ren  = 1'($urandom_range(0, 1));
            hif.id_rs2_ren  = 1'($urandom_range(0, 1));
            hif.id_rs1_idx  = 5'($urandom_range(0, 7));
            hif.id_rs2_idx  = 5'($urandom_range(0, 7));
            hif.id_rsd_idx  = 5'($urandom_range(0, 7));
            hif.id_rsd_wen  = 1'($urandom_range(0, 1));
            hif.ex_valid    = 1'($urandom_range(0, 1));
            hif.ex_rsd_wen  = 1'($urandom_range(0, 1));
            hif.ex_is_load  = 1'($urandom_range(0, 1));
            hif.ex_rsd_idx  = 5'($urandom_range(0, 7));
            hif.mem_valid   = 1'($urandom_range(0, 1));
            hif.mem_rsd_wen = 1'($urandom_range(0, 1));
            hif.mem_rsd_idx = 5'($urandom_range(0, 7));
            hif.wb_valid    = ($urandom_range(0, 2) != 0);
            hif.wb_rsd_wen  = 1'($urandom_range(0, 1));
            hif.wb_rsd_idx  = 5'($urandom_range(0, 7));
            hif.ex_redirect = ($urandom_range(0, 11) == 0);
            hif.mem_busy    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
